// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control unit with integrated PC-enable path.
// Drives every datapath select and write strobe from a single registered
// state; outputs are decoded from state (pc_en also sees zero and mem_ready).
//
// state  | meaning
// -------+---------------------------------------------------------------
// FETCH  | read instruction at PC, PC+4; waits for mem_ready
// DECODE | register read, branch target into ALUOut, dispatch on opcode
// MEMADR | ALUOut <= A + sign-extended imm (lw/sw address)
// MEMRD  | load read, held until mem_ready
// MEMWB  | write load data to rt
// MEMWR  | store write, held until mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | write R-type result to rd
// IEXEC  | addi/andi/ori ALU operation
// IWB    | write immediate result to rt
// BEQ    | compare, take branch if equal
// BNE    | compare, take branch if not equal
// JUMP   | load jump target
// JAL    | r31 <= PC (already +4), load jump target
// TRAP   | illegal instruction; left only by reset
module multicycle_ctrl_fsm #(
    parameter int ALU_CTRL_W      = 3,
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter bit ENABLE_JAL      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  iord,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic [1:0]            reg_dst,
    output logic [1:0]            mem_to_reg,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic                  imm_zext,
    output logic [1:0]            pc_src,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  trap
);

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b010);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b110);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b000);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b001);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b111);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC, S_ALUWB,
        S_IEXEC, S_IWB, S_BEQ, S_BNE, S_JUMP, S_JAL, S_TRAP
    } state_t;

    state_t state;
    state_t state_next;
    state_t illegal_next;
    logic   pc_write;
    logic   branch;
    logic   branch_ne;
    logic   funct_ok;
    logic [ALU_CTRL_W-1:0] funct_alu;

    assign illegal_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

    // R-type funct decode: legality and ALU operation
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'h20:   funct_alu = ALU_ADD;
            6'h22:   funct_alu = ALU_SUB;
            6'h24:   funct_alu = ALU_AND;
            6'h25:   funct_alu = ALU_OR;
            6'h2A:   funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    // State register; reset returns to FETCH, aborting any instruction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_next;
    end

    // Next-state and output decode
    always_comb begin
        state_next = state;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        imm_zext   = 1'b0;
        pc_src     = 2'b00;
        alu_ctrl   = ALU_ADD;
        trap       = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    6'h23, 6'h2B:        state_next = S_MEMADR;
                    6'h00:               state_next = funct_ok ? S_EXEC : illegal_next;
                    6'h08, 6'h0C, 6'h0D: state_next = S_IEXEC;
                    6'h04:               state_next = S_BEQ;
                    6'h05:               state_next = S_BNE;
                    6'h02:               state_next = S_JUMP;
                    6'h03:               state_next = ENABLE_JAL ? S_JAL : illegal_next;
                    default:             state_next = illegal_next;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 2'b01;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = funct_alu;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst    = 2'b01;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    6'h0C: begin alu_ctrl = ALU_AND; imm_zext = 1'b1; end
                    6'h0D: begin alu_ctrl = ALU_OR;  imm_zext = 1'b1; end
                    default: alu_ctrl = ALU_ADD;
                endcase
                state_next = S_IWB;
            end
            S_IWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ, S_BNE: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = ALU_SUB;
                pc_src     = 2'b01;
                branch     = (state == S_BEQ);
                branch_ne  = (state == S_BNE);
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                reg_write  = 1'b1;
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase

        // While reset is held the outputs go quiet at once, not at the next edge
        if (!rst) begin
            iord       = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 2'b00;
            mem_to_reg = 2'b00;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            imm_zext   = 1'b0;
            pc_src     = 2'b00;
            alu_ctrl   = ALU_ADD;
            trap       = 1'b0;
            pc_write   = 1'b0;
            branch     = 1'b0;
            branch_ne  = 1'b0;
        end

        pc_en = pc_write | (branch & zero) | (branch_ne & ~zero);
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm. The main instance runs an
// instruction stream; two alternate instances cover the JAL-disabled and
// illegal-as-NOP parameterisations.
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zext;
        logic [1:0] pc_src;
        logic [2:0] alu_ctrl;
        logic       trap;
    } out_t;

    typedef struct {
        out_t  v;
        string nm;
    } exp_t;

    localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, AND_ = 3'b000, OR_ = 3'b001, SLT = 3'b111;

    function automatic out_t ov(input logic pe, io, mw, iw, rw, input logic [1:0] rd, mr,
                                input logic sa, input logic [1:0] sb, input logic zx,
                                input logic [1:0] ps, input logic [2:0] ac, input logic tr);
        out_t o;
        o = {pe, io, mw, iw, rw, rd, mr, sa, sb, zx, ps, ac, tr};
        return o;
    endfunction

    function automatic out_t v_rst();    return ov(0,0,0,0,0,2'd0,2'd0,0,2'd0,0,2'd0,ADD,0); endfunction
    function automatic out_t v_idle();   return ov(0,0,0,0,0,2'd0,2'd0,0,2'd1,0,2'd0,ADD,0); endfunction
    function automatic out_t v_fetch();  return ov(1,0,0,1,0,2'd0,2'd0,0,2'd1,0,2'd0,ADD,0); endfunction
    function automatic out_t v_dec();    return ov(0,0,0,0,0,2'd0,2'd0,0,2'd3,0,2'd0,ADD,0); endfunction
    function automatic out_t v_memadr(); return ov(0,0,0,0,0,2'd0,2'd0,1,2'd2,0,2'd0,ADD,0); endfunction
    function automatic out_t v_memrd();  return ov(0,1,0,0,0,2'd0,2'd0,0,2'd0,0,2'd0,ADD,0); endfunction
    function automatic out_t v_memwb();  return ov(0,0,0,0,1,2'd0,2'd1,0,2'd0,0,2'd0,ADD,0); endfunction
    function automatic out_t v_memwr();  return ov(0,1,1,0,0,2'd0,2'd0,0,2'd0,0,2'd0,ADD,0); endfunction
    function automatic out_t v_exec(input logic [2:0] ac);
        return ov(0,0,0,0,0,2'd0,2'd0,1,2'd0,0,2'd0,ac,0);
    endfunction
    function automatic out_t v_aluwb();  return ov(0,0,0,0,1,2'd1,2'd0,0,2'd0,0,2'd0,ADD,0); endfunction
    function automatic out_t v_iexec(input logic [2:0] ac, input logic zx);
        return ov(0,0,0,0,0,2'd0,2'd0,1,2'd2,zx,2'd0,ac,0);
    endfunction
    function automatic out_t v_iwb();    return ov(0,0,0,0,1,2'd0,2'd0,0,2'd0,0,2'd0,ADD,0); endfunction
    function automatic out_t v_br(input logic pe);
        return ov(pe,0,0,0,0,2'd0,2'd0,1,2'd0,0,2'd1,SUB,0);
    endfunction
    function automatic out_t v_jump();   return ov(1,0,0,0,0,2'd0,2'd0,0,2'd0,0,2'd2,ADD,0); endfunction
    function automatic out_t v_jal();    return ov(1,0,0,0,1,2'd2,2'd2,0,2'd0,0,2'd2,ADD,0); endfunction
    function automatic out_t v_trap();   return ov(0,0,0,0,0,2'd0,2'd0,0,2'd0,0,2'd0,ADD,1); endfunction

    logic       clk = 1'b0;
    logic       rst_main, rst_nj, rst_nt;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;

    logic m_pc_en, m_iord, m_mw, m_iw, m_rw, m_sa, m_zx, m_trap;
    logic [1:0] m_rd, m_mr, m_sb, m_ps;
    logic [2:0] m_ac;
    logic j_pc_en, j_iord, j_mw, j_iw, j_rw, j_sa, j_zx, j_trap;
    logic [1:0] j_rd, j_mr, j_sb, j_ps;
    logic [2:0] j_ac;
    logic t_pc_en, t_iord, t_mw, t_iw, t_rw, t_sa, t_zx, t_trap;
    logic [1:0] t_rd, t_mr, t_sb, t_ps;
    logic [2:0] t_ac;
    out_t o_main, o_nj, o_nt;

    assign o_main = {m_pc_en, m_iord, m_mw, m_iw, m_rw, m_rd, m_mr, m_sa, m_sb, m_zx, m_ps, m_ac, m_trap};
    assign o_nj   = {j_pc_en, j_iord, j_mw, j_iw, j_rw, j_rd, j_mr, j_sa, j_sb, j_zx, j_ps, j_ac, j_trap};
    assign o_nt   = {t_pc_en, t_iord, t_mw, t_iw, t_rw, t_rd, t_mr, t_sa, t_sb, t_zx, t_ps, t_ac, t_trap};

    multicycle_ctrl_fsm #(.ALU_CTRL_W(3), .TRAP_ON_ILLEGAL(1'b1), .ENABLE_JAL(1'b1)) dut (
        .clk(clk), .rst(rst_main), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(m_pc_en), .iord(m_iord), .mem_write(m_mw), .ir_write(m_iw), .reg_write(m_rw),
        .reg_dst(m_rd), .mem_to_reg(m_mr), .alu_src_a(m_sa), .alu_src_b(m_sb), .imm_zext(m_zx),
        .pc_src(m_ps), .alu_ctrl(m_ac), .trap(m_trap));

    multicycle_ctrl_fsm #(.ALU_CTRL_W(3), .TRAP_ON_ILLEGAL(1'b1), .ENABLE_JAL(1'b0)) dut_nojal (
        .clk(clk), .rst(rst_nj), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(j_pc_en), .iord(j_iord), .mem_write(j_mw), .ir_write(j_iw), .reg_write(j_rw),
        .reg_dst(j_rd), .mem_to_reg(j_mr), .alu_src_a(j_sa), .alu_src_b(j_sb), .imm_zext(j_zx),
        .pc_src(j_ps), .alu_ctrl(j_ac), .trap(j_trap));

    multicycle_ctrl_fsm #(.ALU_CTRL_W(3), .TRAP_ON_ILLEGAL(1'b0), .ENABLE_JAL(1'b1)) dut_notrap (
        .clk(clk), .rst(rst_nt), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(t_pc_en), .iord(t_iord), .mem_write(t_mw), .ir_write(t_iw), .reg_write(t_rw),
        .reg_dst(t_rd), .mem_to_reg(t_mr), .alu_src_a(t_sa), .alu_src_b(t_sb), .imm_zext(t_zx),
        .pc_src(t_ps), .alu_ctrl(t_ac), .trap(t_trap));

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   rw_count = 0;
    exp_t sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every non-idle output cycle of the main instance is popped and compared
    always @(negedge clk) begin
        exp_t e;
        if (rst_main === 1'b1 && o_main !== v_idle()) begin
            if (o_main.reg_write === 1'b1) rw_count++;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_output", 32'(o_main), 32'(v_idle()));
            end else begin
                e = sb_q.pop_front();
                chk(e.nm, 32'(o_main), 32'(e.v));
            end
        end
    end

    task automatic cyc(input out_t e, input string nm);
        exp_t r;
        if (e != v_idle()) begin
            r.v  = e;
            r.nm = nm;
            sb_q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_go();
        mem_ready = 1'b1;
        cyc(v_fetch(), "fetch");
        cyc(v_dec(), "decode");
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] r_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [2:0] r_ac [5] = '{ADD, SUB, AND_, OR_, SLT};
    logic [5:0] i_op [3] = '{6'h08, 6'h0C, 6'h0D};
    logic [2:0] i_ac [3] = '{ADD, AND_, OR_};
    logic       i_zx [3] = '{1'b0, 1'b1, 1'b1};
    logic [5:0] b_op [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
    logic       b_z  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       b_pe [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int rw0;
        rst_main = 1'b0; rst_nj = 1'b0; rst_nt = 1'b0;
        opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
        #2;
        chk("reset_main", 32'(o_main), 32'(v_rst()));
        chk("reset_nojal", 32'(o_nj), 32'(v_rst()));
        chk("reset_notrap", 32'(o_nt), 32'(v_rst()));
        step();
        rst_main = 1'b1;

        for (int i = 0; i < 5; i++) begin
            opcode = 6'h00; funct = r_fn[i];
            fetch_go();
            cyc(v_exec(r_ac[i]), "exec");
            cyc(v_aluwb(), "aluwb");
        end
        for (int i = 0; i < 3; i++) begin
            opcode = i_op[i];
            fetch_go();
            cyc(v_iexec(i_ac[i], i_zx[i]), "iexec");
            cyc(v_iwb(), "iwb");
        end
        for (int i = 0; i < 4; i++) begin
            opcode = b_op[i]; zero = b_z[i];
            fetch_go();
            cyc(v_br(b_pe[i]), "branch");
        end
        zero = 1'b0;
        opcode = 6'h02; fetch_go(); cyc(v_jump(), "jump");
        opcode = 6'h03; fetch_go(); cyc(v_jal(), "jal");
        opcode = 6'h2B; fetch_go(); cyc(v_memadr(), "sw_memadr"); cyc(v_memwr(), "sw_memwr");
        opcode = 6'h23; fetch_go(); cyc(v_memadr(), "lw_memadr"); cyc(v_memrd(), "lw_memrd");
        cyc(v_memwb(), "lw_memwb");

        // reset asserted while a store is held waiting for memory
        opcode = 6'h2B; fetch_go(); cyc(v_memadr(), "sw2_memadr");
        mem_ready = 1'b0;
        cyc(v_memwr(), "sw2_memwr_wait");
        chk("memwr_still_held", 32'(o_main.mem_write), 32'd1);
        rst_main = 1'b0;
        #1;
        chk("reset_mid_memwr", 32'(o_main), 32'(v_rst()));
        step();
        rst_main = 1'b1;

        // lw with two fetch wait states and one load wait state: 8 cycles
        opcode = 6'h23;
        rw0 = rw_count;
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("pc_en_fetch_wait", 32'(o_main.pc_en), 32'd0);
            cyc(v_idle(), "fetch_wait");
        end
        fetch_go();
        cyc(v_memadr(), "lw_memadr");
        mem_ready = 1'b0;
        cyc(v_memrd(), "lw_memrd_wait");
        mem_ready = 1'b1;
        cyc(v_memrd(), "lw_memrd_done");
        cyc(v_memwb(), "lw_memwb");
        opcode = 6'h02; fetch_go(); cyc(v_jump(), "jump_after_lw");
        chk("lw_reg_write_once", 32'(rw_count - rw0), 32'd1);

        // illegal opcode traps and holds
        opcode = 6'h3F; fetch_go();
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            cyc(v_trap(), "trap_hold");
        end
        rst_main = 1'b0;
        step();
        rst_main = 1'b1;

        // illegal R-type funct traps too
        opcode = 6'h00; funct = 6'h3F; fetch_go();
        cyc(v_trap(), "trap_funct");
        cyc(v_trap(), "trap_funct");
        rst_main = 1'b0;
        step();

        // ENABLE_JAL=0: jal is illegal and traps
        rst_nj = 1'b1; opcode = 6'h03; mem_ready = 1'b1;
        step();
        chk("nojal_decode", 32'(o_nj), 32'(v_dec()));
        step();
        chk("nojal_trap", 32'(o_nj), 32'(v_trap()));
        step(); step();
        chk("nojal_trap_held", 32'(o_nj), 32'(v_trap()));
        rst_nj = 1'b0;
        step();

        // TRAP_ON_ILLEGAL=0: illegal opcode/funct return to FETCH without writes
        rst_nt = 1'b1; opcode = 6'h3F; mem_ready = 1'b1;
        step();
        chk("notrap_decode", 32'(o_nt), 32'(v_dec()));
        step();
        chk("notrap_back_fetch", 32'(o_nt), 32'(v_fetch()));
        opcode = 6'h00; funct = 6'h3F;
        step();
        chk("notrap_funct_decode", 32'(o_nt), 32'(v_dec()));
        step();
        chk("notrap_funct_fetch", 32'(o_nt), 32'(v_fetch()));
        rst_nt = 1'b0;
        step(); step();

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
